// File: rtl/msx_mouse_port_pkg.sv
// rtl/msx_mouse_port_pkg.sv - shared constants, phase enum and clamp helper for the MSX mouse port
package msx_mouse_pkg;

  localparam int PS2_LB  = 0;
  localparam int PS2_RB  = 1;
  localparam int PS2_XS  = 4;
  localparam int PS2_YS  = 5;
  localparam int PS2_XLO = 8;
  localparam int PS2_YLO = 16;
  localparam int PS2_TOG = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    P3   = 2'd3
  } mouse_phase_t;

  // Clamp a signed value to the 8-bit range reported to the MSX.
  function automatic logic [7:0] sat8(input logic signed [15:0] v);
    logic [7:0] r;
    if (v > 16'sd127) begin
      r = 8'h7f;
    end else if (v < -16'sd128) begin
      r = 8'h80;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/msx_mouse_port_if.sv
// rtl/msx_mouse_port_if.sv - packet, strobe and joystick-pin bundle between hps_io side and the MSX core
interface msx_mouse_port_if;

  logic [24:0] ps2_mouse;
  logic        strobe;
  logic [5:0]  data;

  modport master (
    output ps2_mouse,
    output strobe,
    input  data
  );

  modport slave (
    input  ps2_mouse,
    input  strobe,
    output data
  );

endinterface

// File: rtl/msx_mouse_port_axis_acc.sv
// rtl/msx_mouse_port_axis_acc.sv - per-axis saturating signed movement accumulator
module mouse_axis_acc
  import msx_mouse_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       add_i,
  input  logic [8:0] delta_i,
  input  logic       neg_i,
  input  logic       latch_i,
  output logic [7:0] sat_o
);

  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] MAX_V = SW'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [9:0]       d10;
  logic signed [SW-1:0]    base;
  logic signed [SW-1:0]    sum;

  always_comb begin
    d10 = {delta_i[8], delta_i};
    if (neg_i) begin
      d10 = -d10;
    end
    // A latch in the same cycle as an add starts the fresh window from the new delta.
    base = latch_i ? '0 : {{(SW - ACC_W){acc_q[ACC_W-1]}}, acc_q};
    sum  = base + {{(SW - 10){d10[9]}}, d10};

    acc_d = acc_q;
    if (add_i) begin
      if (sum > MAX_V) begin
        acc_d = MAX_V[ACC_W-1:0];
      end else if (sum < MIN_V) begin
        acc_d = MIN_V[ACC_W-1:0];
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end else if (latch_i) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sat_o = sat8(16'(acc_q));

endmodule

// File: rtl/msx_mouse_port.sv
// rtl/msx_mouse_port.sv - PS/2 mouse packets to MSX general-purpose-port mouse protocol
module msx_mouse_port
  import msx_mouse_pkg::*;
#(
  parameter int TIMEOUT_CYC = 32000,
  parameter int ACC_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  msx_mouse_port_if.slave  bus
);

  localparam int             CW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  T_MAX = CW'(TIMEOUT_CYC);

  mouse_phase_t  phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    outx_q, outx_d;
  logic [7:0]    outy_q, outy_d;
  logic [3:0]    nib_q, nib_d;
  logic [1:0]    btn_n_q;
  logic          strobe_q;
  logic          tog_q;

  logic          strb_edge;
  logic          pkt;
  logic          latch;
  logic [7:0]    sat_x;
  logic [7:0]    sat_y;

  assign strb_edge = bus.strobe != strobe_q;
  assign pkt       = bus.ps2_mouse[PS2_TOG] != tog_q;

  mouse_axis_acc #(.ACC_W(ACC_W)) u_acc_x (
    .clk     (clk),
    .reset   (reset),
    .add_i   (pkt),
    .delta_i ({bus.ps2_mouse[PS2_XS], bus.ps2_mouse[PS2_XLO +: 8]}),
    .neg_i   (1'b1),
    .latch_i (latch),
    .sat_o   (sat_x)
  );

  mouse_axis_acc #(.ACC_W(ACC_W)) u_acc_y (
    .clk     (clk),
    .reset   (reset),
    .add_i   (pkt),
    .delta_i ({bus.ps2_mouse[PS2_YS], bus.ps2_mouse[PS2_YLO +: 8]}),
    .neg_i   (1'b0),
    .latch_i (latch),
    .sat_o   (sat_y)
  );

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    outx_d  = outx_q;
    outy_d  = outy_q;
    nib_d   = nib_q;
    latch   = 1'b0;

    if (strb_edge) begin
      cnt_d = '0;
      case (phase_q)
        IDLE: begin
          latch   = 1'b1;
          outx_d  = sat_x;
          outy_d  = sat_y;
          nib_d   = sat_x[7:4];
          phase_d = P1;
        end
        P1: begin
          nib_d   = outx_q[3:0];
          phase_d = P2;
        end
        P2: begin
          nib_d   = outy_q[7:4];
          phase_d = P3;
        end
        P3: begin
          nib_d   = outy_q[3:0];
          phase_d = IDLE;
        end
        default: phase_d = IDLE;
      endcase
    end else begin
      if (cnt_q != T_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
      // The count reaching the limit abandons a half-finished read; the nibble is left as is.
      if (cnt_d == T_MAX) begin
        phase_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= IDLE;
      cnt_q    <= '0;
      outx_q   <= '0;
      outy_q   <= '0;
      nib_q    <= '0;
      btn_n_q  <= 2'b11;
      strobe_q <= 1'b0;
      tog_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      outx_q   <= outx_d;
      outy_q   <= outy_d;
      nib_q    <= nib_d;
      strobe_q <= bus.strobe;
      tog_q    <= bus.ps2_mouse[PS2_TOG];
      if (pkt) begin
        btn_n_q <= ~{bus.ps2_mouse[PS2_RB], bus.ps2_mouse[PS2_LB]};
      end
    end
  end

  assign bus.data = {btn_n_q, nib_q};

endmodule
